// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch unit
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - instruction buffer: synchronous FIFO with flush, registered head
module fetch_buf
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage is reset so the head reads zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC sequencing and redirect handling; FETCH_MISALIGN_TRAP_EN enables misaligned-target traps
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        fault_o
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [31:0]   pc_q;
  logic [31:0]   target;
  logic [CW-1:0] count;
  logic          pop;
  logic          space;
  logic          push;
  logic          advance;
  fetch_entry_t  wdata;
  fetch_entry_t  head;

  assign valid_o = (count != '0);
  assign pop     = valid_o && ready_i && !redirect;
  assign space   = (count < CW'(BUF_DEPTH)) || pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic halt_q;
  logic trap_q;
  logic misalign;

  assign misalign = |redirect_pc[1:0];
  assign target   = redirect_pc;
  // While halted only the pending fault marker may enter the buffer.
  assign push     = !redirect && space && (!halt_q || trap_q);
  assign advance  = push && !halt_q;
  assign wdata    = trap_q ? '{pc: pc_q, instr: NOP_INSTR, fault: 1'b1}
                           : '{pc: pc_q, instr: imem_instr, fault: 1'b0};
  assign fault_o  = valid_o && head.fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
      trap_q <= 1'b0;
    end else if (redirect) begin
      halt_q <= misalign;
      trap_q <= misalign;
    end else if (push && trap_q) begin
      trap_q <= 1'b0;
    end
  end
`else
  logic unused_fault;

  assign unused_fault = head.fault;
  assign target       = redirect_pc & ~32'h3;
  assign push         = !redirect && space;
  assign advance      = push;
  assign wdata        = '{pc: pc_q, instr: imem_instr, fault: 1'b0};
  assign fault_o      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pc_q <= RESET_PC;
    else if (redirect) pc_q <= target;
    else if (advance)  pc_q <= pc_q + 32'd4;
  end

  assign imem_pc = pc_q;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  assign instr_o = head.instr;
  assign pc_o    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based reference model
module tb_fetch_unit;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready_i = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        fault_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h1357_9bdf;
  endfunction

  assign imem_instr = mem_f(imem_pc);

  fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .fault_o     (fault_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of the fetch behaviour, as a queue of fetched words.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    if (redirect) begin
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      do_pop  = (mq.size() > 0) && ready_i;
      do_push = (mq.size() < D) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: mpc, instr: mem_f(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic check_state();
    chk("imem_pc", imem_pc, mpc);
    chk("valid_o", {31'b0, valid_o}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      chk("pc_o", pc_o, mq[0].pc);
      chk("instr_o", instr_o, mq[0].instr);
    end
    chk("fault_o", {31'b0, fault_o}, 32'h0);
  endtask

  task automatic raw_step(input bit rd, input logic [31:0] rpc, input bit rdy);
    redirect = rd;
    redirect_pc = rpc;
    ready_i = rdy;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic step(input bit rd, input logic [31:0] rpc, input bit rdy);
    redirect = rd;
    redirect_pc = rpc;
    ready_i = rdy;
    model_step();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    check_state();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid_o}, 32'h0);
    chk("async_rst_pc", imem_pc, 32'h0);
    mq.delete();
    mpc = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit          rd;
    bit          rdy;
    logic [31:0] rpc;

    mq.delete();
    mpc = 32'h0;
    #12;
    chk("rst_imem_pc", imem_pc, 32'h0);
    chk("rst_valid", {31'b0, valid_o}, 32'h0);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_instr_o", instr_o, 32'h0);
    chk("rst_fault", {31'b0, fault_o}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // streaming with ready held high
    step(0, 0, 1);
    chk("first_push_valid", {31'b0, valid_o}, 32'h1);
    chk("first_push_pc", imem_pc, 32'h4);
    for (int i = 0; i < 6; i++) step(0, 0, 1);

    // stall until full, then drain without gaps
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("stall_pc", imem_pc, 32'(4 * D));
    for (int i = 0; i < 8; i++) step(0, 0, 1);

    // redirect while full with ready high
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(1, 32'h100, 1);
    chk("redir_valid", {31'b0, valid_o}, 32'h0);
    step(0, 0, 1);
    chk("redir_pc_o", pc_o, 32'h100);

    // back-to-back redirects
    step(1, 32'h40, 1);
    step(1, 32'h80, 1);
    step(0, 0, 1);
    chk("b2b_pc_o", pc_o, 32'h80);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    // wrap at top of address space
    step(1, 32'hFFFF_FFFC, 1);
    step(0, 0, 1);
    chk("wrap_pc0", pc_o, 32'hFFFF_FFFC);
    step(0, 0, 1);
    chk("wrap_pc1", pc_o, 32'h0);

`ifndef FETCH_MISALIGN_TRAP_EN
    step(1, 32'h10A, 1);
    step(0, 0, 1);
    chk("align_force", pc_o, 32'h108);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rd  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc = rpc & ~32'h3;
`endif
      rdy = ($urandom_range(0, 3) != 0);
      step(rd, rpc, rdy);
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    raw_step(1, 32'h102, 1);
    chk("trap_valid0", {31'b0, valid_o}, 32'h0);
    chk("trap_imem_pc", imem_pc, 32'h102);
    raw_step(0, 0, 1);
    chk("trap_valid1", {31'b0, valid_o}, 32'h1);
    chk("trap_pc_o", pc_o, 32'h102);
    chk("trap_fault", {31'b0, fault_o}, 32'h1);
    chk("trap_instr", instr_o, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      raw_step(0, 0, 1);
      chk("halt_valid", {31'b0, valid_o}, 32'h0);
      chk("halt_pc", imem_pc, 32'h102);
    end
    mq.delete();
    step(1, 32'h200, 1);
    step(0, 0, 1);
    chk("restart_pc", pc_o, 32'h200);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction-buffer entries; legal values 2 or 4.
REQ-003 clk  input  1: sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset is asynchronous and active-low.
REQ-005 imem_pc  output  32: fetch address to the combinational instruction memory (word-indexed by bits [31:2]).
REQ-006 imem_instr  input  32: instruction returned by memory in the same cycle for imem_pc.
REQ-007 redirect  input  1: taken branch/jump from execute; one-cycle pulse.
REQ-008 redirect_pc  input  32: target address, valid when redirect=1.
REQ-009 valid_o  output  1: head entry available to decode.
REQ-010 ready_i  input  1: decode accepts head entry this cycle.
REQ-011 instr_o  output  32: head-entry instruction.
REQ-012 pc_o  output  32: address of instr_o.
REQ-013 fault_o  output  1: head entry is a misaligned-target fault marker.

Function
REQ-014 Fetch pointer pc_q SHALL drive imem_pc directly (no register between pc_q and memory).
REQ-015 Push: when redirect=0 and fetch not halted, and (count<BUF_DEPTH or a pop occurs this cycle), {pc_q, imem_instr} SHALL be written to the buffer tail and pc_q SHALL advance by 4.
REQ-016 Pop: valid_o && ready_i && redirect=0 SHALL remove the head entry.
REQ-017 Simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-018 Full (count=BUF_DEPTH) with no pop: no push; pc_q holds.
REQ-019 valid_o SHALL equal (count!=0); instr_o/pc_o/fault_o SHALL be driven from the head entry (registered, not from imem_instr).
REQ-020 Redirect SHALL take priority over push and pop: buffer cleared (count=0), pc_q<=redirect_pc, no push, head not consumed regardless of ready_i.
REQ-021 Latency: redirect in cycle N -> imem_pc=target in N+1 -> valid_o=1 with pc_o=target in N+2.
REQ-022 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-023 pc_q addition SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), no flag.
REQ-024 Buffer pointers SHALL wrap modulo BUF_DEPTH.

Reset
REQ-025 While rst_n=0: pc_q=RESET_PC, count=0, read/write pointers=0, valid_o=0, fault_o=0, halt flag=0.
REQ-026 instr_o and pc_o SHALL read 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously).
REQ-028 First push SHALL occur in the first rising edge after rst_n deasserts; valid_o=1 one cycle later.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 SHALL push a single entry {pc=redirect_pc, instr=32'h0000_0013, fault=1} in the next cycle and set halt; no further pushes until the next redirect clears halt.
REQ-030 Macro undefined: redirect_pc[1:0] SHALL be forced to 2'b00; fault_o tied 0; no halt logic synthesised.

Structure
REQ-031 Shared package SHALL hold the buffer-entry struct {pc, instr, fault}, NOP constant 32'h0000_0013 and the default RESET_PC.
REQ-032 One sub-module fetch_buf (parameterised synchronous FIFO with flush) is natural; PC logic stays in fetch_unit.

Verification
REQ-033 Reset release, ready_i=1 always: imem_pc steps 0,4,8,... one per cycle; pc_o lags by one cycle; valid_o=1 from second cycle.
REQ-034 ready_i=0 for 5 cycles after reset: count saturates at BUF_DEPTH, imem_pc stalls at 4*BUF_DEPTH; on ready_i=1, pc_o sequence 0,4,8,... with no gap or duplicate.
REQ-035 redirect=1, redirect_pc=32'h100 while full and ready_i=1: head not consumed, valid_o=0 next cycle, pc_o=32'h100 two cycles later.
REQ-036 Redirects to 32'h40 then 32'h80 in consecutive cycles: first pc_o after them is 32'h80; 32'h40 never appears.
REQ-037 Redirect to 32'hFFFF_FFFC: next pc_o values 32'hFFFF_FFFC then 32'h0000_0000.
REQ-038 With FETCH_MISALIGN_TRAP_EN, redirect_pc=32'h102: one entry with fault_o=1, pc_o=32'h102, then valid_o=0 until redirect to 32'h200 restarts fetch.
